err_eval_poly_gen: RTL and testbench
====================================

# err_eval_poly_gen

Parametrised Reed–Solomon error-evaluator block: computes Ω(x) = S(x)·Λ(x) mod x^2T over GF(2^m) from the syndrome vector and the error-locator polynomial. It sits in the decoder between the key-equation solver and the Forney/Chien stage. It generalises the fixed RS(15,9) evaluator to any symbol width, any correction capability and any field polynomial. It adds a full valid/ready handshake on both sides.

## Interface
- WORD_WIDTH, 4, symbol width m (3..8)
- T_NUM, 3, correctable symbols T; T2 = 2·T_NUM
- PRIM_POLY, 'h13, field polynomial incl. x^m term (WORD_WIDTH+1 bits)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands (IDLE only)
- syn_i  in  WORD_WIDTH·T2  word k (bits [m·k +: m]) = S_(k+1), k=0..T2-1
- loc_i  in  WORD_WIDTH·(T_NUM+1)  word j = Λ_j, j=0..T
- out_valid  out  1  Ω valid, held until accepted
- out_ready  in  1  downstream accepts Ω
- omega_o  out  WORD_WIDTH·T2  word k = Ω_k
- omega_deg_o  out  $clog2(T2)  degree of Ω (only with ERR_EVAL_DEG_EN)

## Operation
- States: IDLE → CALC → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, register syn_i and loc_i, clear omega_o, set k=0, go to CALC.
- CALC: one coefficient per cycle, Ω_k = XOR over j=0..min(k,T) of Λ_j ⊗ S_(k+1-j). Use T_NUM+1 parallel GF multipliers and an XOR tree. Write word k, then k++. After writing k=T2-1, go to DONE.
- GF multiply: polynomial product, reduced modulo PRIM_POLY. Result is WORD_WIDTH bits.
- DONE: out_valid=1. omega_o and omega_deg_o are stable. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored; operands are not queued.
- out_ready outside DONE is ignored.
- Registered operands are not affected by input changes after the accept edge.
- Λ_0 is used as given; no normalisation is applied.
- Reset, including mid-CALC or mid-DONE: state=IDLE, in_ready=1, out_valid=0, omega_o=0, omega_deg_o=0, k=0, operand registers=0. The partial result is discarded.

## Timing
- Accept edge = cycle 0. Ω_k is written at edge k+1.
- out_valid rises after edge T2 (6 edges for T=3) and is held until the edge with out_ready=1. out_valid=0 after that edge.
- in_ready rises in the cycle after the out handshake. Minimum initiation interval is T2+2 cycles.
- in_ready and out_valid are registered-state decodes. They are never high in the same cycle.
- omega_o is updated incrementally during CALC and is guaranteed only while out_valid=1.

## Configuration
- ERR_EVAL_DEG_EN defined:
  - omega_deg_o is present.
  - It is updated on each CALC write: if Ω_k≠0, deg=k.
  - Result = index of the highest nonzero coefficient; 0 if Ω≡0.
  - It is valid with out_valid.
- ERR_EVAL_DEG_EN undefined: port and logic are absent. All other behaviour is identical.

## Test plan
All vectors use m=4, T=3, PRIM_POLY='h13.
- Identity locator: Λ=(1,0,0,0), S1..S6=1,2,3,4,5,6 → out_valid 6 cycles after accept; Ω=(1,2,3,4,5,6); deg=5.
- Λ=(1,1,0,0), S=1..6 → Ω=(1,3,1,7,1,3).
- Field reduction: Λ=(2,0,0,0), all S=8 → Ω=(3,3,3,3,3,3), since α·α³=α⁴=x+1.
- Handshake:
  - out_ready held low 10 cycles → out_valid and omega_o stay stable.
  - in_valid pulsed during CALC → ignored.
  - in_ready returns 1 cycle after out handshake.
- Zero syndromes: S=0, Λ=(1,5,7,2) → Ω all 0; deg=0.
- Reset mid-operation: assert rst_n=0 at CALC k=3 → all outputs return to reset values. A fresh operation then produces the correct Ω from the identity-locator case.

Source files
------------

// File: rtl/err_eval_poly_gen.sv
// err_eval_poly_gen: Reed-Solomon error evaluator, omega(x) = S(x)*lambda(x) mod x^2T over GF(2^m)
// Ports: clk, rst_n (async, active-low); in_valid/in_ready accept syn_i (S_1..S_2T) and
// loc_i (lambda_0..lambda_T); out_valid/out_ready deliver omega_o (omega_0..omega_2T-1).
// Optional omega_deg_o (degree of omega) is present only when ERR_EVAL_DEG_EN is defined.
module err_eval_poly_gen #(
  parameter int WORD_WIDTH = 4,
  parameter int T_NUM = 3,
  parameter logic [WORD_WIDTH:0] PRIM_POLY = 'h13
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WORD_WIDTH*2*T_NUM-1:0]         syn_i,
  input  logic [WORD_WIDTH*(T_NUM+1)-1:0]       loc_i,
  output logic                                  out_valid,
  input  logic                                  out_ready,
`ifdef ERR_EVAL_DEG_EN
  output logic [$clog2(2*T_NUM)-1:0]            omega_deg_o,
`endif
  output logic [WORD_WIDTH*2*T_NUM-1:0]         omega_o
);
  localparam int W = WORD_WIDTH;
  localparam int T2 = 2 * T_NUM;
  localparam int KW = $clog2(T2);
  localparam logic [KW-1:0] K_LAST = KW'(T2 - 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [KW-1:0] k;
  logic [W*T2-1:0] syn_r;
  logic [W*(T_NUM+1)-1:0] loc_r;
  logic [W-1:0] prod [T_NUM+1];
  logic [W-1:0] omega_k;
  // MSB-first shift-and-add multiply with on-the-fly reduction by PRIM_POLY
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    p = '0;
    for (int i = W - 1; i >= 0; i--)
      p = {p[W-2:0], 1'b0} ^ (p[W-1] ? PRIM_POLY[W-1:0] : '0) ^ (b[i] ? a : '0);
    return p;
  endfunction
  // multiplier j pairs lambda_j with S_(k+1-j); terms with j > k contribute nothing
  for (genvar j = 0; j <= T_NUM; j++) begin : g_mul
    logic [W-1:0] s;
    always_comb s = (int'(k) >= j) ? syn_r[(int'(k) - j)*W +: W] : '0;
    assign prod[j] = gf_mul(loc_r[j*W +: W], s);
  end
  always_comb begin
    omega_k = '0;
    for (int j = 0; j <= T_NUM; j++) omega_k ^= prod[j];
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef ERR_EVAL_DEG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) omega_deg_o <= '0;
    else if (state == IDLE && in_valid) omega_deg_o <= '0;
    else if (state == CALC && omega_k != '0) omega_deg_o <= k;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      syn_r <= '0;
      loc_r <= '0;
      omega_o <= '0;
    end else if (state == IDLE && in_valid) begin
      state <= CALC;
      k <= '0;
      syn_r <= syn_i;
      loc_r <= loc_i;
      omega_o <= '0;
    end else if (state == CALC) begin
      omega_o[int'(k)*W +: W] <= omega_k;
      k <= (k == K_LAST) ? '0 : k + 1'b1;
      state <= (k == K_LAST) ? DONE : CALC;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_err_eval_poly_gen.sv
// tb_err_eval_poly_gen: directed vector bench for err_eval_poly_gen (m=4, T=3, poly 'h13)
module tb_err_eval_poly_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [23:0] syn_i = '0;
  logic [15:0] loc_i = '0;
  logic in_ready, out_valid;
  logic [23:0] omega_o;
  logic [2:0] omega_deg_o;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [15:0] loc;
    logic [23:0] syn;
    logic [23:0] om;
    int deg;
  } vec_t;
  vec_t v [10];
  always #5 clk = ~clk;
  err_eval_poly_gen #(.WORD_WIDTH(4), .T_NUM(3), .PRIM_POLY(5'h13)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .syn_i(syn_i),
    .loc_i(loc_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ERR_EVAL_DEG_EN
    .omega_deg_o(omega_deg_o),
`endif
    .omega_o(omega_o)
  );
`ifndef ERR_EVAL_DEG_EN
  assign omega_deg_o = '0;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // accept at the first edge, then count edges until out_valid
  task automatic start_op(input vec_t x);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    syn_i = x.syn;
    loc_i = x.loc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    syn_i = ~x.syn;
    loc_i = ~x.loc;
  endtask
  task automatic run_op(input string name, input vec_t x, input bit pulse, input int hold);
    int lat;
    start_op(x);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (pulse && lat == 2) begin
        chk({name, "_in_ready_calc"}, 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        syn_i = 24'hFFFFFF;
        loc_i = 16'hFFFF;
      end else in_valid = 1'b0;
    end
    chk({name, "_latency"}, 32'(lat), 32'd6);
    chk({name, "_omega"}, 32'(omega_o), 32'(x.om));
`ifdef ERR_EVAL_DEG_EN
    chk({name, "_deg"}, 32'(omega_deg_o), 32'(x.deg));
`endif
    chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_omega"}, 32'(omega_o), 32'(x.om));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    v[0] = '{16'h0001, 24'h654321, 24'h654321, 5};
    v[1] = '{16'h0011, 24'h654321, 24'h317131, 5};
    v[2] = '{16'h0002, 24'h888888, 24'h333333, 5};
    v[3] = '{16'h2751, 24'h000000, 24'h000000, 0};
    v[4] = '{16'h0003, 24'h654321, 24'hAFC563, 5};
    v[5] = '{16'h1000, 24'h654321, 24'h321000, 5};
    v[6] = '{16'h0100, 24'h654321, 24'h432100, 5};
    v[7] = '{16'h0008, 24'h888888, 24'hCCCCCC, 5};
    v[8] = '{16'h0001, 24'h000021, 24'h000021, 1};
    v[9] = '{16'h0051, 24'h000001, 24'h000051, 1};
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_omega", 32'(omega_o), 32'd0);
    chk("reset_deg", 32'(omega_deg_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), v[i], 1'b0, 0);
    run_op("hold10", v[1], 1'b0, 10);
    run_op("pulse_calc", v[4], 1'b1, 0);
    start_op(v[1]);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_omega", 32'(omega_o), 32'd0);
    chk("midrst_deg", 32'(omega_deg_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", v[0], 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
